// File: rtl/cvw.sv
// Shared SPI constants and helpers for the flash host and its test harness.
package cvw;

  localparam logic [7:0] SPI_CMD_NOP   = 8'd0;
  localparam logic [7:0] SPI_CMD_READ  = 8'd1;
  localparam logic [7:0] SPI_CMD_WRITE = 8'd2;

  localparam int unsigned SPI_ADR_BITS   = 32;
  localparam int unsigned SPI_CMD_BITS   = 8;
  localparam int unsigned SPI_DATA_BITS  = 8;
  localparam int unsigned SPI_FRAME_BITS = SPI_ADR_BITS + SPI_CMD_BITS + SPI_DATA_BITS;

  // Byte driven on MOSI during the data phase: write data only for writes.
  function automatic logic [7:0] spi_data_byte(input logic [7:0] cmd, input logic [7:0] wdata);
    return (cmd == SPI_CMD_WRITE) ? wdata : 8'h00;
  endfunction

endpackage

// File: rtl/spi_host_sckgen.sv
// SCK half-period divider. Starts in the high half when enabled and is held
// cleared while disabled, so every frame begins from the same phase.
module spi_host_sckgen #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic En,
  output logic Sck,
  output logic SckRise,
  output logic SckFall
);

  localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

  logic [7:0] div_q;
  logic       low_q;
  logic       half_done;

  assign half_done = En & (div_q == DivLast);
  // Strobes mark the cycle whose closing clk edge moves SCK.
  assign SckFall   = half_done & ~low_q;
  assign SckRise   = half_done & low_q;
  assign Sck       = En & ~low_q;

  // Half-period counter and SCK phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= 8'd0;
      low_q <= 1'b0;
    end else if (!En) begin
      div_q <= 8'd0;
      low_q <= 1'b0;
    end else if (half_done) begin
      div_q <= 8'd0;
      low_q <= ~low_q;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

endmodule

// File: rtl/spi_flash_host.sv
// SPI mode-0 host: one 48-bit frame (address, command, data) per request,
// returning the byte read from MISO during the data phase.
module spi_flash_host
  import cvw::*;
#(
  parameter int unsigned CLKDIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAdr,
  input  logic [7:0]  ReqCmd,
  input  logic [7:0]  ReqWData,
  output logic        RspValid,
  output logic [7:0]  RspData,
  output logic        Busy,
  output logic        SCK,
  output logic        CSn,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  localparam logic [7:0] DivLast   = 8'(CLKDIV - 1);
  localparam logic [5:0] FrameBits = 6'(SPI_FRAME_BITS);
  localparam logic [5:0] LastFall  = 6'(SPI_FRAME_BITS - 1);
  localparam logic [5:0] DataStart = 6'(SPI_FRAME_BITS - SPI_DATA_BITS);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  bit_cnt_q;
  logic [47:0] shreg_q;
  logic [7:0]  rdata_q;
  logic        accept;
  logic        sck_en;
  logic        sck_rise;
  logic        sck_fall;

  assign accept = ReqValid & (state_q == StIdle);
  assign sck_en = (state_q == StShift);

  spi_host_sckgen #(
    .CLKDIV(CLKDIV)
  ) u_sckgen (
    .clk    (clk),
    .reset  (reset),
    .En     (sck_en),
    .Sck    (SCK),
    .SckRise(sck_rise),
    .SckFall(sck_fall)
  );

  // Next-state logic; cnt times the CLKDIV-long SETUP, HOLD and GAP states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          cnt_d   = 8'd0;
        end
      end
      StSetup: begin
        if (cnt_q == DivLast) begin
          state_d = StShift;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StShift: begin
        // The rise that would start period 49 instead ends the shift phase,
        // so the last period keeps a full low half inside SHIFT.
        if (sck_rise && (bit_cnt_q == FrameBits)) begin
          state_d = StHold;
          cnt_d   = 8'd0;
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          state_d = StGap;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StGap: begin
        if (cnt_q == DivLast) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and phase counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Falling-edge counter; the 48th fall leaves MOSI on the last data bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= 6'd0;
      shreg_q   <= 48'd0;
    end else if (accept) begin
      bit_cnt_q <= 6'd0;
      shreg_q   <= {ReqAdr, ReqCmd, spi_data_byte(ReqCmd, ReqWData)};
    end else if (sck_fall) begin
      bit_cnt_q <= bit_cnt_q + 6'd1;
      if (bit_cnt_q != LastFall) begin
        shreg_q <= {shreg_q[46:0], 1'b0};
      end
    end
  end

  // MISO capture on the edges that raise SCK during the last eight periods.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 8'd0;
    end else if (sck_rise && (bit_cnt_q >= DataStart) && (bit_cnt_q != FrameBits)) begin
      rdata_q <= {rdata_q[6:0], MISO};
    end
  end

  assign ReqReady = (state_q == StIdle);
  assign Busy     = (state_q != StIdle);
  assign CSn      = (state_q == StIdle) || (state_q == StGap);
  assign MOSI     = ((state_q == StSetup) || (state_q == StShift) || (state_q == StHold))
                    & shreg_q[47];
  assign RspValid = (state_q == StGap) && (cnt_q == 8'd0);
  assign RspData  = rdata_q;

endmodule
